alu_seq_fsm: RTL

Parametrised ALU instruction sequencer for the microcontroller bus datapath. Decodes one ALU instruction per start request, in register-register or register-immediate mode. Drives the ALU operand/result latch strobes, the immediate bus driver and one-hot register-file in/out enables over a shared bus. Supersedes the fixed six-register, immediate-only ALU sequencer, adding runtime mode select, compare (no write-back), illegal-register trapping and a start/busy/done handshake.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_fsm_dec.sv | 25 ++
 rtl/alu_seq_fsm.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, opcode constants and instruction field map
// for the ALU instruction sequencer. Rev 1.0
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [3:0] OP_CMP = 4'hF;

  // Instruction word layout: [15:12] op, [11] mode, [10:8] dst, [7:5] src2, [7:0] imm
  localparam int OPC_LSB  = 12;
  localparam int OPC_W    = 4;
  localparam int MODE_BIT = 11;
  localparam int DST_LSB  = 8;
  localparam int SRC2_LSB = 5;
  localparam int IMM_W    = 8;

  localparam logic MODE_IMM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_seq_fsm_dec.sv
// reg_onehot_dec: register index to one-hot enable, valid when the index
// names an existing register. Rev 1.0
`default_nettype none

module reg_onehot_dec
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 6,
  parameter int SEL_W    = 3
) (
  input  logic [SEL_W-1:0]    idx_i,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                valid_o
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign onehot_o[i] = (idx_i == SEL_W'(i));
  end

  // Out-of-range indices light no bit, so an empty vector means illegal.
  assign valid_o = |onehot_o;

endmodule

`default_nettype wire

// File: rtl/alu_seq_fsm.sv
// alu_seq_fsm: sequences one ALU instruction per start request over the shared
// bus; all outputs are registered alongside the state. Rev 1.0
`default_nettype none

module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int NUM_REGS     = 6,
  parameter int SEL_W        = 3,
  parameter bit SIGN_EXT_IMM = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   instr_i,
  output logic                busy_o,
  output logic [3:0]          alu_op_o,
  output logic                alu_in1_o,
  output logic                alu_in2_o,
  output logic                alu_outlatch_o,
  output logic                alu_out_en_o,
  output logic                imm_out_o,
  output logic [DATA_W-1:0]   imm_value_o,
  output logic [NUM_REGS-1:0] reg_in_o,
  output logic [NUM_REGS-1:0] reg_out_o,
  output logic                pc_inc_o,
  output logic                done_o,
  output logic                err_o
);

  state_t                state_q;
  logic [DATA_W-1:0]     instr_q;
  logic                  busy_q;
  logic [3:0]            alu_op_q;
  logic                  alu_in1_q;
  logic                  alu_in2_q;
  logic                  alu_outlatch_q;
  logic                  alu_out_en_q;
  logic                  imm_out_q;
  logic [DATA_W-1:0]     imm_value_q;
  logic [NUM_REGS-1:0]   reg_in_q;
  logic [NUM_REGS-1:0]   reg_out_q;
  logic                  pc_inc_q;
  logic                  done_q;
  logic                  err_q;

  // In IDLE the live instruction is decoded so the accept edge can load the
  // first cycle's strobes; afterwards the latched copy is decoded.
  logic [DATA_W-1:0]     instr_d;
  logic [NUM_REGS-1:0]   dst_oh_d;
  logic [NUM_REGS-1:0]   src2_oh_d;
  logic                  dst_ok_d;
  logic                  src2_ok_d;
  logic                  mode_imm_d;
  logic                  illegal_d;
  logic [DATA_W-1:0]     imm_ext_d;

  assign instr_d    = (state_q == S_IDLE) ? instr_i : instr_q;
  assign mode_imm_d = (instr_d[MODE_BIT] == MODE_IMM);
  assign illegal_d  = !dst_ok_d || (!mode_imm_d && !src2_ok_d);
  assign imm_ext_d  = {{(DATA_W-IMM_W){instr_d[IMM_W-1] & SIGN_EXT_IMM}},
                       instr_d[IMM_W-1:0]};

  reg_onehot_dec #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_dst_dec (
    .idx_i    (instr_d[DST_LSB +: SEL_W]),
    .onehot_o (dst_oh_d),
    .valid_o  (dst_ok_d)
  );

  reg_onehot_dec #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_src2_dec (
    .idx_i    (instr_d[SRC2_LSB +: SEL_W]),
    .onehot_o (src2_oh_d),
    .valid_o  (src2_ok_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      instr_q        <= '0;
      busy_q         <= 1'b0;
      alu_op_q       <= '0;
      alu_in1_q      <= 1'b0;
      alu_in2_q      <= 1'b0;
      alu_outlatch_q <= 1'b0;
      alu_out_en_q   <= 1'b0;
      imm_out_q      <= 1'b0;
      imm_value_q    <= '0;
      reg_in_q       <= '0;
      reg_out_q      <= '0;
      pc_inc_q       <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      alu_in1_q      <= 1'b0;
      alu_in2_q      <= 1'b0;
      alu_outlatch_q <= 1'b0;
      alu_out_en_q   <= 1'b0;
      imm_out_q      <= 1'b0;
      reg_in_q       <= '0;
      reg_out_q      <= '0;
      pc_inc_q       <= 1'b0;
      done_q         <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            instr_q     <= instr_i;
            busy_q      <= 1'b1;
            alu_op_q    <= instr_d[OPC_LSB +: OPC_W];
            imm_value_q <= imm_ext_d;
            err_q       <= illegal_d;
            if (illegal_d) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              pc_inc_q <= 1'b1;
            end else begin
              state_q   <= S_LOAD_A;
              reg_out_q <= dst_oh_d;
              alu_in1_q <= 1'b1;
            end
          end
        end

        S_LOAD_A: begin
          state_q   <= S_LOAD_B;
          alu_in2_q <= 1'b1;
          if (mode_imm_d) begin
            imm_out_q <= 1'b1;
          end else begin
            reg_out_q <= src2_oh_d;
          end
        end

        S_LOAD_B: begin
          state_q        <= S_EXEC;
          alu_outlatch_q <= 1'b1;
        end

        S_EXEC: begin
          // Compare only updates the ALU flags, so there is no write-back.
          if (alu_op_q == OP_CMP) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            pc_inc_q <= 1'b1;
          end else begin
            state_q      <= S_WRITE;
            alu_out_en_q <= 1'b1;
            reg_in_q     <= dst_oh_d;
          end
        end

        S_WRITE: begin
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          pc_inc_q <= 1'b1;
        end

        S_DONE: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          alu_op_q    <= '0;
          imm_value_q <= '0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign alu_op_o       = alu_op_q;
  assign alu_in1_o      = alu_in1_q;
  assign alu_in2_o      = alu_in2_q;
  assign alu_outlatch_o = alu_outlatch_q;
  assign alu_out_en_o   = alu_out_en_q;
  assign imm_out_o      = imm_out_q;
  assign imm_value_o    = imm_value_q;
  assign reg_in_o       = reg_in_q;
  assign reg_out_o      = reg_out_q;
  assign pc_inc_o       = pc_inc_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

`default_nettype wire
